// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with WAW scoreboard; zero-latency reads, writes/busy update on next edge.
// Issue stalls (iss_ready_o low) while the destination is busy; REGFILE_SB_BYPASS_EN forwards same-cycle write data to reads.
module regfile_sb #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int NRP  = 2,
  parameter  int NWP  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NRP*AW-1:0]    rd_addr_i,
  output logic [NRP*XLEN-1:0]  rd_data_o,
  output logic [NRP-1:0]       rd_busy_o,
  input  logic                 iss_valid_i,
  input  logic [AW-1:0]        iss_addr_i,
  output logic                 iss_ready_o,
  input  logic [NWP-1:0]       wr_en_i,
  input  logic [NWP*AW-1:0]    wr_addr_i,
  input  logic [NWP*XLEN-1:0]  wr_data_i,
  output logic [NREG-1:0]      busy_o,
  output logic                 wr_conflict_o
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic            conflict_q, conflict_d;
  logic            iss_fire;

  logic [AW-1:0]   rd_addr [NRP];
  logic [AW-1:0]   wr_addr [NWP];
  logic [XLEN-1:0] wr_data [NWP];

  for (genvar p = 0; p < NRP; p++) begin : g_rd_unpack
    assign rd_addr[p] = rd_addr_i[p*AW +: AW];
  end

  for (genvar w = 0; w < NWP; w++) begin : g_wr_unpack
    assign wr_addr[w] = wr_addr_i[w*AW +: AW];
    assign wr_data[w] = wr_data_i[w*XLEN +: XLEN];
  end

  // Stall decision uses registered busy only, so it never depends on same-cycle writes.
  assign iss_ready_o = (iss_addr_i == '0) || !busy_q[iss_addr_i];
  assign iss_fire    = iss_valid_i && iss_ready_o && (iss_addr_i != '0);

  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NWP; w++) begin
      if (wr_en_i[w]) busy_d[wr_addr[w]] = 1'b0;
    end
    if (iss_fire) busy_d[iss_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    conflict_d = 1'b0;
    for (int i = 0; i < NWP; i++) begin
      for (int j = i + 1; j < NWP; j++) begin
        if (wr_en_i[i] && wr_en_i[j] && (wr_addr[i] == wr_addr[j]) && (wr_addr[i] != '0))
          conflict_d = 1'b1;
      end
    end
  end

  // Ascending port loop: the highest-indexed writer's assignment lands last and wins.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      for (int w = 0; w < NWP; w++) begin
        if (wr_en_i[w] && (wr_addr[w] != '0)) regs[wr_addr[w]] <= wr_data[w];
      end
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int p = 0; p < NRP; p++) begin
      rd_data_o[p*XLEN +: XLEN] = regs[rd_addr[p]];
      rd_busy_o[p]              = busy_q[rd_addr[p]];
`ifdef REGFILE_SB_BYPASS_EN
      if (rd_addr[p] != '0) begin
        for (int w = 0; w < NWP; w++) begin
          if (wr_en_i[w] && (wr_addr[w] == rd_addr[p])) begin
            rd_data_o[p*XLEN +: XLEN] = wr_data[w];
            rd_busy_o[p]              = iss_fire && (iss_addr_i == rd_addr[p]);
          end
        end
      end
`endif
    end
  end

  assign busy_o        = busy_q;
  assign wr_conflict_o = conflict_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus randomized traffic against an array-based reference model.
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int NWP  = 2;
  localparam int AW   = 5;
`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk_i = 1'b0;
  logic                rst_n_i;
  logic [NRP*AW-1:0]   rd_addr;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]      rd_busy;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic                iss_ready;
  logic [NWP-1:0]      wr_en;
  logic [NWP*AW-1:0]   wr_addr;
  logic [NWP*XLEN-1:0] wr_data;
  logic [NREG-1:0]     busy;
  logic                wr_conflict;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .iss_valid_i(iss_valid), .iss_addr_i(iss_addr), .iss_ready_o(iss_ready),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .busy_o(busy), .wr_conflict_o(wr_conflict)
  );

  always #5 clk_i = ~clk_i;

  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];
  bit              m_conf;
  int              n_checks = 0;
  int              n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    m_conf = 1'b0;
  endtask

  function automatic bit model_fire();
    return iss_valid && (iss_addr != 0) && !m_busy[iss_addr];
  endfunction

  // Highest-indexed enabled port writing address a, or -1.
  function automatic int last_writer(input logic [AW-1:0] a);
    int hit = -1;
    for (int w = 0; w < NWP; w++)
      if (wr_en[w] && wr_addr[w*AW +: AW] == a) hit = w;
    return hit;
  endfunction

  task automatic check_all();
    logic [NREG-1:0] eb;
    for (int p = 0; p < NRP; p++) begin
      logic [AW-1:0]   a = rd_addr[p*AW +: AW];
      logic [XLEN-1:0] ed = (a == 0) ? '0 : m_regs[a];
      bit              ebz = (a == 0) ? 1'b0 : m_busy[a];
      int              w = last_writer(a);
      if (BYP && a != 0 && w >= 0) begin
        ed  = wr_data[w*XLEN +: XLEN];
        ebz = model_fire() && iss_addr == a;
      end
      chk($sformatf("rd_data%0d(x%0d)", p, a), rd_data[p*XLEN +: XLEN], ed);
      chk($sformatf("rd_busy%0d(x%0d)", p, a), rd_busy[p], ebz);
    end
    for (int r = 0; r < NREG; r++) eb[r] = m_busy[r];
    chk("busy_o", busy, eb);
    chk("iss_ready", iss_ready, (iss_addr == 0) || !m_busy[iss_addr]);
    chk("wr_conflict", wr_conflict, m_conf);
  endtask

  task automatic model_update();
    bit fire = model_fire();
    m_conf = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      int writers = 0;
      int w = last_writer(r[AW-1:0]);
      for (int k = 0; k < NWP; k++)
        if (wr_en[k] && wr_addr[k*AW +: AW] == r[AW-1:0]) writers++;
      if (writers > 1) m_conf = 1'b1;
      if (w >= 0) begin
        m_regs[r] = wr_data[w*XLEN +: XLEN];
        m_busy[r] = 1'b0;
      end
    end
    if (fire) m_busy[iss_addr] = 1'b1;
  endtask

  task automatic idle();
    rd_addr = '0; iss_valid = 1'b0; iss_addr = '0;
    wr_en = '0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic cycle();
    #1;
    check_all();
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
  endtask

  initial begin
    rst_n_i = 1'b0;
    idle();
    model_reset();
    @(negedge clk_i);
    #1;
    chk("reset_busy_o", busy, '0);
    chk("reset_iss_ready", iss_ready, 1'b1);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Read every register on both ports after reset.
    for (int r = 0; r < NREG; r += 2) begin
      rd_addr = {AW'(r + 1), AW'(r)};
      cycle();
    end

    // x5 <= DEADBEEF on port 0; x0 write on port 1 is discarded.
    wr_en = 2'b11;
    wr_addr = {AW'(0), AW'(5)};
    wr_data = {32'h1234_5678, 32'hDEAD_BEEF};
    cycle();
    idle();
    rd_addr = {AW'(0), AW'(5)};
    #1;
    chk("x5_after_write", rd_data[31:0], 32'hDEAD_BEEF);
    chk("x0_ignores_write", rd_data[63:32], 32'h0);
    cycle();

    // WAW stall on x7, cleared by a write.
    iss_valid = 1'b1; iss_addr = 7;
    cycle();
    #1;
    chk("x7_busy", busy[7], 1'b1);
    chk("x7_reissue_stalled", iss_ready, 1'b0);
    cycle();
    iss_valid = 1'b0;
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(7)}; wr_data = {32'h0, 32'h55};
    cycle();
    idle();
    iss_addr = 7; rd_addr = {AW'(0), AW'(7)};
    #1;
    chk("x7_busy_cleared", busy[7], 1'b0);
    chk("x7_issue_ready", iss_ready, 1'b1);
    chk("x7_data", rd_data[31:0], 32'h55);
    cycle();

    // Same-address write on both ports: port 1 wins, one-cycle conflict pulse.
    wr_en = 2'b11; wr_addr = {AW'(9), AW'(9)}; wr_data = {32'h2222, 32'h1111};
    cycle();
    idle();
    rd_addr = {AW'(0), AW'(9)};
    #1;
    chk("x9_high_port_wins", rd_data[31:0], 32'h2222);
    chk("conflict_pulse", wr_conflict, 1'b1);
    cycle();
    #1;
    chk("conflict_one_cycle", wr_conflict, 1'b0);
    cycle();

    // Busy x3 written while being read.
    iss_valid = 1'b1; iss_addr = 3;
    cycle();
    idle();
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(3)}; wr_data = {32'h0, 32'hA5A5_A5A5};
    rd_addr = {AW'(0), AW'(3)};
    #1;
    chk("x3_same_cycle_data", rd_data[31:0], BYP ? 32'hA5A5_A5A5 : 32'h0);
    chk("x3_same_cycle_busy", rd_busy[0], BYP ? 1'b0 : 1'b1);
    cycle();
    idle();
    rd_addr = {AW'(0), AW'(3)};
    #1;
    chk("x3_next_cycle_data", rd_data[31:0], 32'hA5A5_A5A5);
    cycle();

    // Issue and write x4 in the same cycle: data lands, busy stays set.
    iss_valid = 1'b1; iss_addr = 4;
    wr_en = 2'b10; wr_addr = {AW'(4), AW'(0)}; wr_data = {32'h44, 32'h0};
    cycle();
    idle();
    rd_addr = {AW'(0), AW'(4)};
    #1;
    chk("x4_set_wins", busy[4], 1'b1);
    chk("x4_data", rd_data[31:0], 32'h44);
    rst_n_i = 1'b0;
    #1;
    model_reset();
    chk("async_reset_busy_o", busy, '0);
    chk("async_reset_x4", rd_data[31:0], 32'h0);
    chk("async_reset_ready", iss_ready, 1'b1);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    cycle();

    // Randomized traffic over a narrow address window to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < NRP; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
      iss_valid = 1'($urandom_range(0, 1));
      iss_addr  = AW'($urandom_range(0, 7));
      for (int w = 0; w < NWP; w++) begin
        wr_en[w] = ($urandom_range(0, 2) == 0);
        wr_addr[w*AW +: AW] = AW'($urandom_range(0, 7));
        wr_data[w*XLEN +: XLEN] = $urandom;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
